// File: rtl/lr35902_oam_dma.sv
// OAM DMA engine: a write to FF46 copies LENGTH bytes from {page,00} on the
// system bus into sprite attribute RAM, one byte every four clocks.
module lr35902_oam_dma #(
    parameter int START_DELAY = 4,
    parameter int LENGTH      = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  reg_din,
    input  logic        reg_write,
    output logic [7:0]  reg_dout,
    output logic [15:0] bus_adr,
    output logic        bus_read,
    input  logic [7:0]  bus_din,
    output logic [7:0]  oam_adr,
    output logic [7:0]  oam_dout,
    output logic        oam_write,
    output logic        active,
    output logic        busy
);
    localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    state_t          state_q;
    logic [DW-1:0]   delay_q;
    logic [1:0]      phase_q;
    logic [8:0]      cnt_q;
    logic [7:0]      page_q;
    logic [7:0]      reg_dout_q;
    logic [15:0]     bus_adr_q;
    logic            bus_read_q;
    logic [7:0]      oam_adr_q;
    logic [7:0]      oam_dout_q;
    logic            oam_write_q;
    logic            active_q;
    logic            busy_q;

    logic [7:0]      page_d;
    logic [7:0]      idx;
    logic [7:0]      idx_nx;
    logic            last_byte;

    // Sources at E000 and above alias work RAM at C000 (echo region).
    assign page_d    = (reg_din >= 8'hE0) ? (reg_din - 8'h20) : reg_din;
    // Byte count is 9 bits so LENGTH=256 ends on the count, not on idx wrap.
    assign idx       = cnt_q[7:0];
    assign idx_nx    = cnt_q[7:0] + 8'd1;
    assign last_byte = (cnt_q == 9'(LENGTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            delay_q     <= '0;
            phase_q     <= '0;
            cnt_q       <= '0;
            page_q      <= '0;
            reg_dout_q  <= '0;
            bus_adr_q   <= '0;
            bus_read_q  <= 1'b0;
            oam_adr_q   <= '0;
            oam_dout_q  <= '0;
            oam_write_q <= 1'b0;
            active_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else if (reg_write) begin
            // A new write always wins: abort any copy and restart the delay.
            reg_dout_q  <= reg_din;
            page_q      <= page_d;
            delay_q     <= DW'(START_DELAY - 1);
            cnt_q       <= '0;
            phase_q     <= '0;
            state_q     <= START;
            busy_q      <= 1'b1;
            active_q    <= 1'b0;
            bus_read_q  <= 1'b0;
            oam_write_q <= 1'b0;
        end else begin
            case (state_q)
                START: begin
                    if (delay_q == '0) begin
                        state_q    <= XFER;
                        active_q   <= 1'b1;
                        bus_adr_q  <= {page_q, 8'h00};
                        bus_read_q <= 1'b1;
                        phase_q    <= 2'd0;
                    end else begin
                        delay_q <= delay_q - DW'(1);
                    end
                end
                XFER: begin
                    case (phase_q)
                        2'd0: phase_q <= 2'd1;
                        2'd1: begin
                            phase_q     <= 2'd2;
                            bus_read_q  <= 1'b0;
                            oam_dout_q  <= bus_din;
                            oam_adr_q   <= idx;
                            oam_write_q <= 1'b1;
                        end
                        // Address and data stay put through p3 so the strobe fall commits them.
                        2'd2: begin
                            phase_q     <= 2'd3;
                            oam_write_q <= 1'b0;
                        end
                        default: begin
                            phase_q <= 2'd0;
                            if (last_byte) begin
                                state_q  <= IDLE;
                                active_q <= 1'b0;
                                busy_q   <= 1'b0;
                            end else begin
                                cnt_q      <= cnt_q + 9'd1;
                                bus_adr_q  <= {page_q, idx_nx};
                                bus_read_q <= 1'b1;
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign reg_dout  = reg_dout_q;
    assign bus_adr   = bus_adr_q;
    assign bus_read  = bus_read_q;
    assign oam_adr   = oam_adr_q;
    assign oam_dout  = oam_dout_q;
    assign oam_write = oam_write_q;
    assign active    = active_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lr35902_oam_dma.sv
// Directed bench for lr35902_oam_dma: system memory and OAM models plus a
// per-clock phase monitor for strobe, read and address sequencing.
module tb_lr35902_oam_dma;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  reg_din = 8'h00;
    logic        reg_write = 1'b0;
    logic [7:0]  reg_dout;
    logic [15:0] bus_adr;
    logic        bus_read;
    logic [7:0]  bus_din = 8'h00;
    logic [7:0]  oam_adr;
    logic [7:0]  oam_dout;
    logic        oam_write;
    logic        active;
    logic        busy;

    logic [7:0]  mem [0:65535];
    logic [7:0]  oam [0:255];

    int          n_tot = 0;
    int          n_bad = 0;
    int          busy_cnt = 0;
    int          act_cnt = 0;
    int          act_pos = 0;
    int          viol = 0;
    int          rd_cnt = 0;
    int          ph, by;
    logic [7:0]  exp_hi = 8'h00;
    logic [7:0]  p2_adr = 8'h00;
    logic [7:0]  p2_dout = 8'h00;

    lr35902_oam_dma dut (
        .clk       (clk),
        .reset     (reset),
        .reg_din   (reg_din),
        .reg_write (reg_write),
        .reg_dout  (reg_dout),
        .bus_adr   (bus_adr),
        .bus_read  (bus_read),
        .bus_din   (bus_din),
        .oam_adr   (oam_adr),
        .oam_dout  (oam_dout),
        .oam_write (oam_write),
        .active    (active),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Memory answers one clock after the read request.
    always @(posedge clk) if (bus_read) bus_din <= mem[bus_adr];

    // OAM commits on the falling edge of its write strobe.
    always @(negedge oam_write) oam[oam_adr] <= oam_dout;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (bus_read) rd_cnt++;
        if (active) begin
            act_cnt++;
            ph = act_pos % 4;
            by = act_pos / 4;
            if (bus_read !== (ph < 2)) viol++;
            if (oam_write !== (ph == 2)) viol++;
            if (ph == 0 && bus_adr !== {exp_hi, by[7:0]}) viol++;
            if (ph == 2) begin
                if (oam_adr !== by[7:0]) viol++;
                p2_adr  = oam_adr;
                p2_dout = oam_dout;
            end
            if (ph == 3 && (oam_adr !== p2_adr || oam_dout !== p2_dout)) viol++;
            act_pos++;
        end else begin
            act_pos = 0;
            if (bus_read !== 1'b0 || oam_write !== 1'b0) viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    // Called just after a falling edge; the write is taken at the next rising edge.
    task automatic drive_write(input logic [7:0] v, input logic [7:0] hi);
        reg_din   = v;
        reg_write = 1'b1;
        busy_cnt  = 0;
        act_cnt   = 0;
        exp_hi    = hi;
        sync();
        reg_write = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 2000 && busy; k++) sync();
        chk(tag, busy, 0);
    endtask

    task automatic wait_pos(input string tag, input int p);
        for (int k = 0; k < 2000 && act_pos != p; k++) sync();
        chk(tag, act_pos, p);
    endtask

    task automatic check_oam(input string tag, input bit inc, input logic [7:0] val);
        int errs = 0;
        for (int k = 0; k < 160; k++) begin
            logic [7:0] e = inc ? 8'(k) : val;
            if (oam[k] !== e) errs++;
        end
        chk(tag, errs, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 65536; k++) mem[k] = 8'hFF;
        for (int k = 0; k < 256; k++) oam[k] = 8'h00;
        for (int k = 0; k < 160; k++) begin
            mem[16'hC000 + k] = 8'(k);
            mem[16'hC500 + k] = 8'hA5;
            mem[16'hD000 + k] = 8'h3C;
        end

        // Reset state
        sync(); sync();
        chk("rst_busy", busy, 0);
        chk("rst_active", active, 0);
        chk("rst_strobes", {bus_read, oam_write}, 0);
        chk("rst_adr", {bus_adr, oam_adr}, 0);
        chk("rst_data", {reg_dout, oam_dout}, 0);
        reset = 1'b0;
        sync();

        // Basic copy from C000
        viol = 0;
        drive_write(8'hC0, 8'hC0);
        chk("basic_start", {busy, active}, 2'b10);
        wait_idle("basic_done");
        chk("basic_busy_clks", busy_cnt, 644);
        chk("basic_act_clks", act_cnt, 640);
        chk("basic_seq", viol, 0);
        chk("basic_reg_dout", reg_dout, 8'hC0);
        check_oam("basic_oam", 1'b1, 8'h00);
        chk("basic_last_adr", bus_adr, 16'hC09F);

        // Echo mapping E5 -> C5
        viol = 0;
        drive_write(8'hE5, 8'hC5);
        chk("echo_reg_dout", reg_dout, 8'hE5);
        wait_idle("echo_done");
        chk("echo_busy_clks", busy_cnt, 644);
        chk("echo_seq", viol, 0);
        chk("echo_last_adr", bus_adr, 16'hC59F);
        check_oam("echo_oam", 1'b0, 8'hA5);

        // Restart mid-copy at byte 50 with page D0
        viol = 0;
        drive_write(8'hC0, 8'hC0);
        wait_pos("restart_reach", 202);
        drive_write(8'hD0, 8'hD0);
        chk("restart_start", {busy, active}, 2'b10);
        sync(); sync(); sync(); sync();
        chk("restart_first_adr", bus_adr, 16'hD000);
        chk("restart_first_rd", {bus_read, active}, 2'b11);
        wait_idle("restart_done");
        chk("restart_busy_clks", busy_cnt, 644);
        chk("restart_seq", viol, 0);
        check_oam("restart_oam", 1'b0, 8'h3C);

        // Asynchronous reset during p2 of byte 20
        viol = 0;
        drive_write(8'hC0, 8'hC0);
        wait_pos("rst_reach", 83);
        chk("rst_in_p2", oam_write, 1);
        reset = 1'b1;
        #1;
        chk("rstmid_ctl", {busy, active, bus_read, oam_write}, 0);
        chk("rstmid_adr", {bus_adr, oam_adr}, 0);
        chk("rstmid_data", {reg_dout, oam_dout}, 0);
        rd_cnt = 0;
        sync(); sync();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) sync();
        chk("rstmid_no_read", rd_cnt, 0);
        chk("rstmid_idle", busy, 0);
        drive_write(8'hC0, 8'hC0);
        wait_idle("rstmid_redo");
        chk("rstmid_redo_clks", busy_cnt, 644);
        chk("rstmid_seq", viol, 0);
        check_oam("rstmid_oam", 1'b1, 8'h00);

        // Write on the final clock of a transfer
        viol = 0;
        drive_write(8'hD0, 8'hD0);
        wait_pos("final_reach", 640);
        drive_write(8'hC0, 8'hC0);
        chk("final_restart", {busy, active}, 2'b10);
        wait_idle("final_done");
        chk("final_busy_clks", busy_cnt, 644);
        chk("final_act_clks", act_cnt, 640);
        chk("final_seq", viol, 0);
        check_oam("final_oam", 1'b1, 8'h00);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
